dram_bank_responder: RTL and testbench

Synthesizable device-side responder for the DRAM command interface driven by `dram_ctrl`: it receives bank/row/column commands from the controller and models banked DRAM storage with per-bank open-row state, activate/precharge timing and fixed CAS read latency. It replaces the behavioural bank model in system-level benches and serves as the far end of the controller's DRAM port.

---
 rtl/dram_bank_responder_if.sv | 34 +++
 rtl/dram_bank_responder.sv | 167 ++++++++++++++++
 tb/tb_dram_bank_responder.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_bank_responder_if.sv
// Command/data bus between a DRAM controller (master) and the bank responder (slave).
// Widths follow the same geometry parameters as the responder itself.
interface dram_bank_responder_if #(
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int DATA_WIDTH   = 8
);
    localparam int BANK_W = $clog2(NUM_OF_BANKS);
    localparam int ROW_W  = $clog2(NUM_OF_ROWS);
    localparam int COL_W  = $clog2(NUM_OF_COLS);

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [1:0]              cmd;
    logic [BANK_W-1:0]       bank_id;
    logic [ROW_W-1:0]        row_id;
    logic [COL_W-1:0]        col_id;
    logic [DATA_WIDTH-1:0]   din;
    logic [DATA_WIDTH-1:0]   dout;
    logic                    dout_valid;
    logic [NUM_OF_BANKS-1:0] bank_open;
    logic                    cmd_err;

    modport master (
        output cmd_valid, cmd, bank_id, row_id, col_id, din,
        input  cmd_ready, dout, dout_valid, bank_open, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd, bank_id, row_id, col_id, din,
        output cmd_ready, dout, dout_valid, bank_open, cmd_err
    );
endinterface

// File: rtl/dram_bank_responder.sv
// dram_bank_responder: device-side model of banked DRAM storage. Each bank runs its own
// IDLE/ACTIVATING/ACTIVE/PRECHARGING state machine with T_RCD/T_RP timers, and reads come
// back through a fixed CAS_LAT-deep pipeline.
// Optional feature: define DRAM_RESP_ERR_CHECK_EN to pulse cmd_err for one cycle after an
// illegal command is accepted. Without it cmd_err is tied low; illegal commands are still
// ignored (no state or memory change) in both builds.
module dram_bank_responder #(
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int T_RCD        = 2,
    parameter int T_RP         = 2,
    parameter int CAS_LAT      = 3
) (
    input logic                  clk,
    input logic                  rst,
    dram_bank_responder_if.slave bus
);
    localparam int BANK_W    = $clog2(NUM_OF_BANKS);
    localparam int ROW_W     = $clog2(NUM_OF_ROWS);
    localparam int COL_W     = $clog2(NUM_OF_COLS);
    localparam int ADDR_W    = BANK_W + ROW_W + COL_W;
    localparam int MEM_DEPTH = NUM_OF_BANKS * NUM_OF_ROWS * NUM_OF_COLS;
    localparam int T_MAX     = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int TMR_W     = $clog2(T_MAX + 1);

    localparam logic [1:0] CMD_ACT = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_PRE = 2'b11;

    typedef enum logic [1:0] {
        BANK_IDLE,
        BANK_ACTIVATING,
        BANK_ACTIVE,
        BANK_PRECHARGING
    } bank_state_t;

    bank_state_t           state_q [NUM_OF_BANKS];
    bank_state_t           state_d [NUM_OF_BANKS];
    logic [TMR_W-1:0]      timer_q [NUM_OF_BANKS];
    logic [TMR_W-1:0]      timer_d [NUM_OF_BANKS];
    logic [ROW_W-1:0]      row_q   [NUM_OF_BANKS];
    logic [ROW_W-1:0]      row_d   [NUM_OF_BANKS];

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [DATA_WIDTH-1:0] pipe_data [CAS_LAT];
    logic [CAS_LAT-1:0]    pipe_valid;

    bank_state_t           sel_state;
    logic                  cmd_accept;
    logic                  cmd_legal;
    logic                  rd_fire;
    logic                  wr_fire;
    logic [ADDR_W-1:0]     mem_addr;
    logic [NUM_OF_BANKS-1:0] open_vec;

    // The addressed bank decides readiness; a timing bank blocks only commands aimed at it.
    assign sel_state     = state_q[bus.bank_id];
    assign bus.cmd_ready = (sel_state == BANK_IDLE) || (sel_state == BANK_ACTIVE);
    assign cmd_accept    = bus.cmd_valid && bus.cmd_ready;
    assign cmd_legal     = (bus.cmd == CMD_ACT) ? (sel_state == BANK_IDLE)
                                                : (sel_state == BANK_ACTIVE);
    assign rd_fire       = cmd_accept && cmd_legal && (bus.cmd == CMD_RD);
    assign wr_fire       = cmd_accept && cmd_legal && (bus.cmd == CMD_WR);
    assign mem_addr      = {bus.bank_id, row_q[bus.bank_id], bus.col_id};

    // Per-bank next state: run down the ACT/PRE timers, then apply a legal ACT or PRE.
    always_comb begin
        for (int i = 0; i < NUM_OF_BANKS; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            row_d[i]   = row_q[i];
            case (state_q[i])
                BANK_ACTIVATING: begin
                    if (timer_q[i] == '0) state_d[i] = BANK_ACTIVE;
                    else                  timer_d[i] = timer_q[i] - 1'b1;
                end
                BANK_PRECHARGING: begin
                    if (timer_q[i] == '0) state_d[i] = BANK_IDLE;
                    else                  timer_d[i] = timer_q[i] - 1'b1;
                end
                default: ;
            endcase
        end
        if (cmd_accept && cmd_legal) begin
            case (bus.cmd)
                CMD_ACT: begin
                    state_d[bus.bank_id] = BANK_ACTIVATING;
                    timer_d[bus.bank_id] = TMR_W'(T_RCD - 1);
                    row_d[bus.bank_id]   = bus.row_id;
                end
                CMD_PRE: begin
                    state_d[bus.bank_id] = BANK_PRECHARGING;
                    timer_d[bus.bank_id] = TMR_W'(T_RP - 1);
                end
                default: ;
            endcase
        end
    end

    // Bank state, timers and open rows; reset returns every bank to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_OF_BANKS; i++) begin
                state_q[i] <= BANK_IDLE;
                timer_q[i] <= '0;
                row_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OF_BANKS; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
                row_q[i]   <= row_d[i];
            end
        end
    end

    // Storage array is deliberately outside reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[mem_addr] <= bus.din;
    end

    // Read pipeline: the word is captured at acceptance and shifted CAS_LAT stages; data
    // only moves with a valid token so the last stage holds the previous read word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int k = 0; k < CAS_LAT; k++) pipe_data[k] <= '0;
        end else begin
            pipe_valid[0] <= rd_fire;
            if (rd_fire) pipe_data[0] <= mem[mem_addr];
            for (int k = 1; k < CAS_LAT; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                if (pipe_valid[k-1]) pipe_data[k] <= pipe_data[k-1];
            end
        end
    end

    assign bus.dout       = pipe_data[CAS_LAT-1];
    assign bus.dout_valid = pipe_valid[CAS_LAT-1];

    // One bit per bank, high only once the row is fully open.
    always_comb begin
        open_vec = '0;
        for (int i = 0; i < NUM_OF_BANKS; i++) open_vec[i] = (state_q[i] == BANK_ACTIVE);
    end

    assign bus.bank_open = open_vec;

`ifdef DRAM_RESP_ERR_CHECK_EN
    logic err_q;

    // Registered one-cycle flag for a command accepted against the wrong bank state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= cmd_accept && !cmd_legal;
    end

    assign bus.cmd_err = err_q;
`else
    assign bus.cmd_err = 1'b0;
`endif

endmodule

// File: tb/tb_dram_bank_responder.sv
// Testbench for dram_bank_responder: directed command sequences checked every cycle against
// a timestamp-based model of bank availability, memory and read latency, plus literal checks
// of the key cycle counts and data values.
module tb_dram_bank_responder;
    localparam int NB   = 8;
    localparam int NR   = 128;
    localparam int NC   = 8;
    localparam int DW   = 8;
    localparam int TRCD = 2;
    localparam int TRP  = 2;
    localparam int CL   = 3;
    localparam int BW   = $clog2(NB);
    localparam int RW   = $clog2(NR);
    localparam int CW   = $clog2(NC);

    localparam logic [1:0] ACT = 2'b00;
    localparam logic [1:0] RD  = 2'b01;
    localparam logic [1:0] WR  = 2'b10;
    localparam logic [1:0] PRE = 2'b11;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dram_bank_responder_if #(
        .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC), .DATA_WIDTH(DW)
    ) bus ();

    dram_bank_responder #(
        .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC), .DATA_WIDTH(DW),
        .T_RCD(TRCD), .T_RP(TRP), .CAS_LAT(CL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    int edge_n     = 0;

    typedef struct packed {
        int          due;
        logic [DW-1:0] data;
    } rd_t;

    typedef struct packed {
        int          edge_at;
        logic [DW-1:0] data;
    } log_t;

    bit            m_open       [NB];
    int            m_busy_until [NB];
    int            m_row        [NB];
    logic [DW-1:0] m_mem        [int];
    rd_t           m_rdq        [$];
    int            m_err_edge;
    logic [DW-1:0] m_last_dout;

    log_t          rd_log  [$];
    int            err_log [$];

    function automatic int addrOf(input int b, input int r, input int c);
        return (b * NR + r) * NC + c;
    endfunction

    function automatic bit modelReady(input int b);
        return edge_n >= m_busy_until[b];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NB; i++) begin
            m_open[i]       = 1'b0;
            m_busy_until[i] = 0;
            m_row[i]        = 0;
        end
        m_rdq.delete();
        m_err_edge  = -1;
        m_last_dout = '0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, edge_n);
        end
    endtask

    // Model: a bank is unavailable until its busy timestamp; memory is a sparse array.
    always @(posedge rst) modelReset();

    always @(posedge clk) begin
        int  b;
        int  n;
        int  a;
        bit  legal;
        if (rst) begin
            modelReset();
        end else if (bus.cmd_valid === 1'b1 && modelReady(int'(bus.bank_id))) begin
            b     = int'(bus.bank_id);
            n     = edge_n + 1;
            legal = (bus.cmd == ACT) ? !m_open[b] : m_open[b];
            if (!legal) begin
                m_err_edge = n;
            end else begin
                a = addrOf(b, m_row[b], int'(bus.col_id));
                case (bus.cmd)
                    ACT: begin
                        m_open[b]       = 1'b1;
                        m_row[b]        = int'(bus.row_id);
                        m_busy_until[b] = n + TRCD;
                    end
                    PRE: begin
                        m_open[b]       = 1'b0;
                        m_busy_until[b] = n + TRP;
                    end
                    WR: m_mem[a] = bus.din;
                    default: m_rdq.push_back('{due: n + CL - 1,
                                               data: m_mem.exists(a) ? m_mem[a] : '0});
                endcase
            end
        end
        edge_n++;
    end

    // Compare all outputs against the model once per cycle, and log read/error events.
    always @(negedge clk) begin
        logic [NB-1:0] exp_open;
        logic          exp_valid;
        logic [DW-1:0] exp_dout;
        logic          exp_err;
        if (rst === 1'b0) begin
            checkOutput("cmd_ready", bus.cmd_ready, modelReady(int'(bus.bank_id)));
            for (int i = 0; i < NB; i++) exp_open[i] = m_open[i] && (edge_n >= m_busy_until[i]);
            checkOutput("bank_open", bus.bank_open, exp_open);
            while (m_rdq.size() > 0 && m_rdq[0].due < edge_n) void'(m_rdq.pop_front());
            exp_valid = 1'b0;
            exp_dout  = m_last_dout;
            if (m_rdq.size() > 0 && m_rdq[0].due == edge_n) begin
                exp_valid   = 1'b1;
                exp_dout    = m_rdq[0].data;
                m_last_dout = exp_dout;
                void'(m_rdq.pop_front());
            end
            checkOutput("dout_valid", bus.dout_valid, exp_valid);
            checkOutput("dout", bus.dout, exp_dout);
`ifdef DRAM_RESP_ERR_CHECK_EN
            exp_err = (m_err_edge == edge_n);
`else
            exp_err = 1'b0;
`endif
            checkOutput("cmd_err", bus.cmd_err, exp_err);
            if (bus.dout_valid === 1'b1) rd_log.push_back('{edge_at: edge_n, data: bus.dout});
            if (bus.cmd_err === 1'b1) err_log.push_back(edge_n);
        end
    end

    // Present one command for one cycle; returns the edge number that accepts it.
    task automatic applyStimulus(input logic [1:0] c, input int b, input int r, input int col,
                                 input logic [DW-1:0] d, output int acc_edge);
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        bus.bank_id   = BW'(b);
        bus.row_id    = RW'(r);
        bus.col_id    = CW'(col);
        bus.din       = d;
        acc_edge      = edge_n + 1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            e;
        int            r;
        int            p;
        logic [DW-1:0] exp4 [4];
        exp4 = '{8'h11, 8'h77, 8'h22, 8'h88};

        modelReset();
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd       = ACT;
        bus.bank_id   = '0;
        bus.row_id    = '0;
        bus.col_id    = '0;
        bus.din       = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values
        @(negedge clk);
        checkOutput("reset_bank_open", bus.bank_open, 0);
        checkOutput("reset_dout_valid", bus.dout_valid, 0);
        checkOutput("reset_dout", bus.dout, 0);
        checkOutput("reset_cmd_err", bus.cmd_err, 0);
        @(posedge clk);
        #1;

        // ACT bank 2 row 5: two busy cycles, then open
        applyStimulus(ACT, 2, 5, 0, 8'h00, e);
        repeat (2) begin
            @(negedge clk);
            checkOutput("act_busy_ready", bus.cmd_ready, 0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("act_ready_again", bus.cmd_ready, 1);
        checkOutput("act_bank_open", bus.bank_open, 8'b0000_0100);
        @(posedge clk);
        #1;

        // WR then RD same address next cycle
        rd_log.delete();
        applyStimulus(WR, 2, 0, 3, 8'hA5, e);
        applyStimulus(RD, 2, 0, 3, 8'h00, r);
        idleCycles(5);
        checkOutput("wr_rd_count", rd_log.size(), 1);
        if (rd_log.size() >= 1) begin
            checkOutput("wr_rd_latency_edge", rd_log[0].edge_at, r + 2);
            checkOutput("wr_rd_data", rd_log[0].data, 8'hA5);
        end

        // Two banks, interleaved back-to-back reads
        applyStimulus(ACT, 0, 10, 0, 8'h00, e);
        applyStimulus(ACT, 7, 20, 0, 8'h00, e);
        idleCycles(2);
        applyStimulus(WR, 0, 0, 1, 8'h11, e);
        applyStimulus(WR, 7, 0, 1, 8'h77, e);
        applyStimulus(WR, 0, 0, 2, 8'h22, e);
        applyStimulus(WR, 7, 0, 2, 8'h88, e);
        rd_log.delete();
        applyStimulus(RD, 0, 0, 1, 8'h00, r);
        applyStimulus(RD, 7, 0, 1, 8'h00, e);
        applyStimulus(RD, 0, 0, 2, 8'h00, e);
        applyStimulus(RD, 7, 0, 2, 8'h00, e);
        idleCycles(6);
        checkOutput("burst_count", rd_log.size(), 4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++) begin
            checkOutput("burst_edge", rd_log[i].edge_at, r + 2 + i);
            checkOutput("burst_data", rd_log[i].data, exp4[i]);
        end

        // Illegal commands: RD to IDLE bank 4, ACT to already-open bank 0
        rd_log.delete();
        err_log.delete();
        applyStimulus(RD, 4, 0, 0, 8'h00, e);
        applyStimulus(ACT, 0, 3, 0, 8'h00, p);
        idleCycles(5);
`ifdef DRAM_RESP_ERR_CHECK_EN
        checkOutput("err_pulse_count", err_log.size(), 2);
        if (err_log.size() >= 2) begin
            checkOutput("err_rd_edge", err_log[0], e);
            checkOutput("err_act_edge", err_log[1], p);
        end
`else
        checkOutput("err_tied_low", err_log.size(), 0);
`endif
        checkOutput("illegal_no_data", rd_log.size(), 0);
        @(negedge clk);
        checkOutput("illegal_bank_open", bus.bank_open, 8'b1000_0101);
        @(posedge clk);
        #1;

        // PRE right after RD: data still delivered, bank busy two cycles then re-ACT
        rd_log.delete();
        applyStimulus(RD, 2, 0, 3, 8'h00, r);
        applyStimulus(PRE, 2, 0, 0, 8'h00, p);
        @(negedge clk);
        checkOutput("pre_bank_open", bus.bank_open, 8'b1000_0001);
        checkOutput("pre_busy_ready", bus.cmd_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("pre_busy_ready", bus.cmd_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("pre_ready_again", bus.cmd_ready, 1);
        @(posedge clk);
        #1;
        applyStimulus(ACT, 2, 5, 0, 8'h00, e);
        idleCycles(3);
        checkOutput("pre_rd_count", rd_log.size(), 1);
        if (rd_log.size() >= 1) begin
            checkOutput("pre_rd_edge", rd_log[0].edge_at, r + 2);
            checkOutput("pre_rd_data", rd_log[0].data, 8'hA5);
        end

        // Reset while a read is in flight; memory survives
        rd_log.delete();
        applyStimulus(RD, 0, 0, 1, 8'h00, r);
        #2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idleCycles(5);
        checkOutput("rst_no_data", rd_log.size(), 0);
        @(negedge clk);
        checkOutput("rst_bank_open", bus.bank_open, 0);
        @(posedge clk);
        #1;
        applyStimulus(ACT, 0, 10, 0, 8'h00, e);
        idleCycles(2);
        applyStimulus(RD, 0, 0, 1, 8'h00, r);
        idleCycles(5);
        checkOutput("retained_count", rd_log.size(), 1);
        if (rd_log.size() >= 1) begin
            checkOutput("retained_edge", rd_log[0].edge_at, r + 2);
            checkOutput("retained_data", rd_log[0].data, 8'h11);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
